// File: rtl/ysyx_22050612_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx_22050612_mdu                                            |
// | Description : Iterative RV64M multiply/divide unit (radix-2, one bit per   |
// |               cycle) with valid/ready handshakes on request and result.    |
// |               Optional MDU_EARLY_OUT_EN retires trivial cases after one    |
// |               BUSY cycle.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ysyx_22050612_mdu #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_w,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int         c_CNT_W   = $clog2(XLEN);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;
    localparam logic [2:0] c_OP_MUL  = 3'd0;
    localparam logic [2:0] c_OP_MULH = 3'd1;
    localparam logic [2:0] c_OP_MHSU = 3'd2;
    localparam logic [2:0] c_OP_DIV  = 3'd4;
    localparam logic [2:0] c_OP_REM  = 3'd6;

    function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] x);
        logic [XLEN-1:0] r;
        r       = {XLEN{x[31]}};
        r[31:0] = x;
        return r;
    endfunction

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_last;
    logic [2:0]          r_op;
    logic                r_is_w;
    logic                r_neg;
    logic                r_special;
    logic [XLEN-1:0]     r_spec_res;
    logic [TAG_W-1:0]    r_tag;
    logic [2*XLEN-1:0]   r_prod;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_dvsr;

    // Request decode: W ops work on the low word, 1..3 with in_w collapse to MULW.
    logic                w_is_w;
    logic [2:0]          w_op;
    logic                w_is_div;
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [XLEN-1:0]     w_mask;
    logic [XLEN-1:0]     w_min_pat;
    logic [XLEN-1:0]     w_a_n;
    logic [XLEN-1:0]     w_b_n;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_dbz;
    logic                w_ovf;
    logic                w_mzero;
    logic                w_special;
    logic                w_neg_res;
    logic [XLEN-1:0]     w_spec_res;
    logic [c_CNT_W-1:0]  w_last;

    assign w_is_w    = (XLEN == 64) && in_w;
    assign w_op      = (w_is_w && (in_op != c_OP_MUL) && !in_op[2]) ? c_OP_MUL : in_op;
    assign w_is_div  = w_op[2];
    assign w_a_sgn   = (w_op == c_OP_MULH) || (w_op == c_OP_MHSU) ||
                       (w_op == c_OP_DIV)  || (w_op == c_OP_REM);
    assign w_b_sgn   = (w_op == c_OP_MULH) || (w_op == c_OP_DIV) || (w_op == c_OP_REM);
    assign w_mask    = w_is_w ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
    assign w_min_pat = w_is_w ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_a_n     = in_src1 & w_mask;
    assign w_b_n     = in_src2 & w_mask;
    assign w_a_neg   = w_a_sgn && (w_is_w ? in_src1[31] : in_src1[XLEN-1]);
    assign w_b_neg   = w_b_sgn && (w_is_w ? in_src2[31] : in_src2[XLEN-1]);
    assign w_a_mag   = w_a_neg ? ((-w_a_n) & w_mask) : w_a_n;
    assign w_b_mag   = w_b_neg ? ((-w_b_n) & w_mask) : w_b_n;
    assign w_dbz     = w_is_div && (w_b_n == '0);
    assign w_ovf     = w_is_div && w_a_sgn && (w_a_n == w_min_pat) && (w_b_n == w_mask);
    assign w_mzero   = !w_is_div && ((w_a_n == '0) || (w_b_n == '0));
    assign w_special = w_dbz || w_ovf || w_mzero;
    assign w_neg_res = (w_is_div && w_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    always_comb begin
        w_spec_res = '0;
        if (w_dbz) begin
            if (w_op[1])
                w_spec_res = w_is_w ? f_sext32(in_src1[31:0]) : in_src1;
            else
                w_spec_res = {XLEN{1'b1}};
        end else if (w_ovf && !w_op[1]) begin
            w_spec_res = w_is_w ? f_sext32(w_min_pat[31:0]) : w_min_pat;
        end
    end

`ifdef MDU_EARLY_OUT_EN
    assign w_last = w_special ? '0 : (w_is_w ? c_CNT_W'(31) : c_CNT_W'(XLEN-1));
`else
    assign w_last = w_is_w ? c_CNT_W'(31) : c_CNT_W'(XLEN-1);
`endif

    // One shift-add multiply step and one restoring divide step per BUSY cycle.
    logic [2*XLEN-1:0]   w_prod_nx;
    logic [XLEN:0]       w_shift;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_nx;
    logic [XLEN-1:0]     w_quo_nx;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo_s;
    logic [XLEN-1:0]     w_rem_s;
    logic [XLEN-1:0]     w_raw;
    logic [XLEN-1:0]     w_final;

    assign w_prod_nx = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvsr});
    assign w_rem_nx  = w_ge ? (w_shift[XLEN-1:0] - r_dvsr) : w_shift[XLEN-1:0];
    assign w_quo_nx  = {r_quo[XLEN-2:0], w_ge};

    // Magnitude results get their sign applied on the final step.
    assign w_prod_s  = r_neg ? -w_prod_nx : w_prod_nx;
    assign w_quo_s   = r_neg ? -w_quo_nx  : w_quo_nx;
    assign w_rem_s   = r_neg ? -w_rem_nx  : w_rem_nx;
    assign w_raw     = r_op[2] ? (r_op[1] ? w_rem_s : w_quo_s)
                               : ((r_op == c_OP_MUL) ? w_prod_s[XLEN-1:0]
                                                     : w_prod_s[2*XLEN-1:XLEN]);
    assign w_final   = r_special ? r_spec_res : (r_is_w ? f_sext32(w_raw[31:0]) : w_raw);

    assign in_ready  = (r_state == c_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            r_state   <= c_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_state    <= c_BUSY;
                        r_cnt      <= '0;
                        r_last     <= w_last;
                        r_op       <= w_op;
                        r_is_w     <= w_is_w;
                        r_neg      <= w_neg_res;
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        r_tag      <= in_tag;
                        r_prod     <= '0;
                        r_mcand    <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier   <= w_b_mag;
                        r_rem      <= '0;
                        r_quo      <= w_is_w ? (w_a_mag << (XLEN - 32)) : w_a_mag;
                        r_dvsr     <= w_b_mag;
                    end
                end
                c_BUSY: begin
                    r_prod   <= w_prod_nx;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_nx;
                    r_quo    <= w_quo_nx;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == r_last) begin
                        r_state    <= c_DONE;
                        out_valid  <= 1'b1;
                        out_result <= w_final;
                        out_tag    <= r_tag;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state   <= c_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ysyx_22050612_mdu                                         |
// | Description : Directed + random self-checking bench for ysyx_22050612_mdu. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ysyx_22050612_mdu;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_w, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ysyx_22050612_mdu #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_w(in_w),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural RV64M results computed with plain wide arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic signed [63:0]  sa, sb;
        logic [31:0]         ua32, ub32;
        logic signed [31:0]  sa32, sb32;
        sa = $signed(a); sb = $signed(b);
        ua32 = a[31:0]; ub32 = b[31:0];
        sa32 = $signed(ua32); sb32 = $signed(ub32);
        if (w) begin
            case (op)
                3'd4: begin
                    if (ub32 == 0) return '1;
                    if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) return sx32(32'h8000_0000);
                    return sx32(32'(sa32 / sb32));
                end
                3'd5: return (ub32 == 0) ? '1 : sx32(ua32 / ub32);
                3'd6: begin
                    if (ub32 == 0) return sx32(ua32);
                    if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) return 64'd0;
                    return sx32(32'(sa32 % sb32));
                end
                3'd7: return (ub32 == 0) ? sx32(ua32) : sx32(ua32 % ub32);
                default: return sx32(32'(ua32 * ub32));
            endcase
        end
        case (op)
            3'd0: return a * b;
            3'd1: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return sp[127:64];
            end
            3'd2: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                return sp[127:64];
            end
            3'd3: begin
                up = {64'd0, a} * {64'd0, b};
                return up[127:64];
            end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                return 64'(sa / sb);
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                return 64'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the accepting edge to the one that raises out_valid.
    function automatic int exp_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] an, bn, mn;
        bit          special;
        an = w ? {32'd0, a[31:0]} : a;
        bn = w ? {32'd0, b[31:0]} : b;
        mn = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        if (op[2])
            special = (bn == 0) || (!op[0] && an == mn && bn == (w ? 64'hFFFF_FFFF : '1));
        else
            special = (an == 0) || (bn == 0);
`ifdef MDU_EARLY_OUT_EN
        if (special) return 1;
`else
        if (special) return w ? 32 : 64;
`endif
        return w ? 32 : 64;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return 64'($urandom_range(1, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input string name);
        int cnt;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_w = w; in_src1 = a; in_src2 = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_busy_ready"}, 64'(in_ready), 64'd0);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, 64'(cnt), 64'(exp_lat(op, w, a, b)));
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        if (out_ready) begin
            @(posedge clk); #1;
            check({name, "_release"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;
        int          seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_w = 1'b0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", out_result, 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);

        do_op(3'd0, 1'b0, 64'd7, -64'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, "mul_7x-3");
        do_op(3'd3, 1'b0, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_max");
        do_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd2,
              64'h4000_0000_0000_0000, "mulh_min");
        do_op(3'd4, 1'b0, 64'd5, 64'd0, 5'd3, '1, "div_by0");
        do_op(3'd6, 1'b0, 64'd5, 64'd0, 5'd4, 64'd5, "rem_by0");
        do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd5, 64'h8000_0000_0000_0000, "div_ovf");
        do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd6, 64'd0, "rem_ovf");
        do_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd7, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
        do_op(3'd7, 1'b1, 64'h1_0000_0007, 64'd2, 5'd8, 64'd1, "remuw");
        do_op(3'd0, 1'b0, 64'h1234_5678, 64'd0, 5'd10, 64'd0, "mul_x0");

        // Consumer back-pressure: result and tag must hold while out_ready is low.
        out_ready = 1'b0;
        do_op(3'd0, 1'b0, 64'd123, 64'd456, 5'd17, 64'd56088, "stall");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", out_result, 64'd56088);
            check("stall_tag", 64'(out_tag), 64'd17);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", 64'(out_valid), 64'd0);
        check("stall_release_ready", 64'(in_ready), 64'd1);

        // Flush at BUSY cycle 10.
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd4; in_w = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_tag = 5'd11;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);

        // Flush together with a request must not accept it.
        @(negedge clk); flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        check("flush_no_accept", 64'(in_ready), 64'd1);

        // Reset at BUSY cycle 10 of a new op.
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd9; in_src2 = 64'd9; in_tag = 5'd12;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);

        do_op(3'd4, 1'b0, -64'd7, 64'd2, 5'd13, -64'd3, "div_-7_2");
        do_op(3'd6, 1'b0, -64'd7, 64'd2, 5'd14, -64'd1, "rem_-7_2");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            do_op(op, w, a, b, 5'($urandom_range(0, 31)), model(op, w, a, b),
                  $sformatf("rand%0d_op%0d_w%0d", i, op, w));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
